// File: rtl/dbus_ctrl.sv
// Data-bus controller between the LSU and the registered memory bus: it checks alignment,
// moves data and strobes into the right byte lanes, and stalls the core while an access runs.
// The optional bus timeout is built in when DBUS_TIMEOUT_EN is defined.
module dbus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbus_rd_en,
  input  logic        dbus_wr_en,
  input  logic [31:0] dbus_addr,
  input  logic [1:0]  dbus_size,
  input  logic [31:0] dbus_wr_data,
  input  logic [3:0]  dbus_wr_strobe,
  output logic [31:0] dbus_rd_data,
  output logic        dbus_wait,
  output logic        dbus_err,
  output logic        dbus_misaligned,
  output logic        dbus_access_fault,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_strobe,
  input  logic        mem_ready,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_err
);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e      state_q;
  logic        mem_valid_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wr_data_q;
  logic [3:0]  mem_wr_strobe_q;
  logic [1:0]  offset_q;
  logic [31:0] rd_data_q;
  logic        err_q;

  logic        req;
  logic        misaligned;
  logic        start;
  logic [31:0] wr_data_shifted;
  logic [3:0]  wr_strobe_shifted;
  logic [31:0] rd_data_shifted;

  assign req = dbus_rd_en | dbus_wr_en;

  always_comb begin
    misaligned = 1'b0;
    unique case (dbus_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = dbus_addr[0];
      2'd2:    misaligned = (dbus_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign start = (state_q == StIdle) & req & ~misaligned;

  assign wr_data_shifted   = dbus_wr_data << {dbus_addr[1:0], 3'b000};
  assign wr_strobe_shifted = dbus_wr_strobe << dbus_addr[1:0];
  assign rd_data_shifted   = mem_rd_data >> {offset_q, 3'b000};

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            tmo_hit;

  // Fires on the last permitted BUS cycle without a response.
  assign tmo_hit = (tmo_cnt_q == TmoLast);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      mem_valid_q     <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 32'h0;
      mem_wr_data_q   <= 32'h0;
      mem_wr_strobe_q <= 4'h0;
      offset_q        <= 2'b00;
      rd_data_q       <= 32'h0;
      err_q           <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      tmo_cnt_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          err_q <= 1'b0;
          if (start) begin
            state_q         <= StBus;
            mem_valid_q     <= 1'b1;
            // A simultaneous read and write request is treated as a write only.
            mem_we_q        <= dbus_wr_en;
            mem_addr_q      <= {dbus_addr[31:2], 2'b00};
            mem_wr_data_q   <= dbus_wr_en ? wr_data_shifted : 32'h0;
            mem_wr_strobe_q <= dbus_wr_en ? wr_strobe_shifted : 4'h0;
            offset_q        <= dbus_addr[1:0];
`ifdef DBUS_TIMEOUT_EN
            tmo_cnt_q       <= '0;
`endif
          end
        end
        StBus: begin
          if (mem_ready) begin
            state_q     <= StDone;
            mem_valid_q <= 1'b0;
            rd_data_q   <= mem_we_q ? 32'h0 : rd_data_shifted;
            err_q       <= mem_err;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (tmo_hit) begin
            state_q     <= StDone;
            mem_valid_q <= 1'b0;
            rd_data_q   <= 32'h0;
            err_q       <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        StDone: begin
          // Always return to idle so a request still held by the core is not reissued here.
          state_q <= StIdle;
        end
        default: begin
          state_q     <= StIdle;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_valid     = mem_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign mem_wr_strobe = mem_wr_strobe_q;

  assign dbus_rd_data      = rd_data_q;
  assign dbus_wait         = start | (state_q == StBus);
  assign dbus_misaligned   = (state_q == StIdle) & req & misaligned;
  assign dbus_access_fault = (state_q == StDone) & err_q;
  assign dbus_err          = dbus_misaligned | dbus_access_fault;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: aligned loads/stores, misalignment, slow and failing slaves,
// back-to-back requests, asynchronous reset and (with DBUS_TIMEOUT_EN) the bus timeout.
module tb_dbus_ctrl;

  logic        clk;
  logic        rst_n;
  logic        dbus_rd_en;
  logic        dbus_wr_en;
  logic [31:0] dbus_addr;
  logic [1:0]  dbus_size;
  logic [31:0] dbus_wr_data;
  logic [3:0]  dbus_wr_strobe;
  logic [31:0] dbus_rd_data;
  logic        dbus_wait;
  logic        dbus_err;
  logic        dbus_misaligned;
  logic        dbus_access_fault;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strobe;
  logic        mem_ready;
  logic [31:0] mem_rd_data;
  logic        mem_err;

  int checks;
  int failures;

  dbus_ctrl #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dbus_rd_en       (dbus_rd_en),
    .dbus_wr_en       (dbus_wr_en),
    .dbus_addr        (dbus_addr),
    .dbus_size        (dbus_size),
    .dbus_wr_data     (dbus_wr_data),
    .dbus_wr_strobe   (dbus_wr_strobe),
    .dbus_rd_data     (dbus_rd_data),
    .dbus_wait        (dbus_wait),
    .dbus_err         (dbus_err),
    .dbus_misaligned  (dbus_misaligned),
    .dbus_access_fault(dbus_access_fault),
    .mem_valid        (mem_valid),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wr_data      (mem_wr_data),
    .mem_wr_strobe    (mem_wr_strobe),
    .mem_ready        (mem_ready),
    .mem_rd_data      (mem_rd_data),
    .mem_err          (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step to one time unit after the next falling edge.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    dbus_rd_en     = 1'b0;
    dbus_wr_en     = 1'b0;
    dbus_addr      = 32'h0;
    dbus_size      = 2'd0;
    dbus_wr_data   = 32'h0;
    dbus_wr_strobe = 4'h0;
    mem_ready      = 1'b0;
    mem_rd_data    = 32'h0;
    mem_err        = 1'b0;

    nxt();
    nxt();
    chk("rst_valid", mem_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wr_data, 0);
    chk("rst_strobe", mem_wr_strobe, 0);
    chk("rst_rdata", dbus_rd_data, 0);
    chk("rst_wait", dbus_wait, 0);
    chk("rst_err", dbus_err, 0);
    rst_n = 1'b1;
    nxt();

    // LW 0x100, immediate ready
    dbus_rd_en = 1'b1; dbus_addr = 32'h100; dbus_size = 2'd2;
    #1;
    chk("lw_idle_wait", dbus_wait, 1);
    chk("lw_idle_valid", mem_valid, 0);
    nxt();
    chk("lw_bus_valid", mem_valid, 1);
    chk("lw_bus_addr", mem_addr, 32'h100);
    chk("lw_bus_we", mem_we, 0);
    chk("lw_bus_wait", dbus_wait, 1);
    mem_ready = 1'b1; mem_rd_data = 32'hDEADBEEF;
    nxt();
    chk("lw_done_wait", dbus_wait, 0);
    chk("lw_done_rdata", dbus_rd_data, 32'hDEADBEEF);
    chk("lw_done_err", dbus_err, 0);
    chk("lw_done_valid", mem_valid, 0);
    mem_ready = 1'b0; dbus_rd_en = 1'b0;
    nxt();
    chk("lw_hold_rdata", dbus_rd_data, 32'hDEADBEEF);
    chk("lw_hold_wait", dbus_wait, 0);

    // LB 0x203 picks the top byte
    dbus_rd_en = 1'b1; dbus_addr = 32'h203; dbus_size = 2'd0;
    mem_ready = 1'b1; mem_rd_data = 32'h11223344;
    nxt();
    chk("lb_bus_addr", mem_addr, 32'h200);
    chk("lb_bus_strobe", mem_wr_strobe, 0);
    nxt();
    chk("lb_done_rdata", dbus_rd_data, 32'h00000011);
    dbus_rd_en = 1'b0; mem_ready = 1'b0;
    nxt();

    // SH 0x302 with read also requested: write wins
    dbus_wr_en = 1'b1; dbus_rd_en = 1'b1; dbus_addr = 32'h302; dbus_size = 2'd1;
    dbus_wr_data = 32'h0000ABCD; dbus_wr_strobe = 4'h3; mem_ready = 1'b1;
    #1;
    chk("sh_idle_wait", dbus_wait, 1);
    nxt();
    chk("sh_bus_we", mem_we, 1);
    chk("sh_bus_addr", mem_addr, 32'h300);
    chk("sh_bus_wdata", mem_wr_data, 32'hABCD0000);
    chk("sh_bus_strobe", mem_wr_strobe, 4'hC);
    nxt();
    chk("sh_done_rdata", dbus_rd_data, 0);
    chk("sh_done_err", dbus_err, 0);
    dbus_wr_en = 1'b0; dbus_rd_en = 1'b0; mem_ready = 1'b0;
    nxt();

    // Misaligned requests never reach the bus
    dbus_rd_en = 1'b1; dbus_addr = 32'h102; dbus_size = 2'd2;
    #1;
    chk("mis_lw_err", dbus_err, 1);
    chk("mis_lw_mis", dbus_misaligned, 1);
    chk("mis_lw_wait", dbus_wait, 0);
    chk("mis_lw_fault", dbus_access_fault, 0);
    nxt();
    chk("mis_lw_valid", mem_valid, 0);
    chk("mis_lw_err2", dbus_err, 1);
    dbus_addr = 32'h100; dbus_size = 2'd3;
    #1;
    chk("mis_sz3", dbus_misaligned, 1);
    dbus_addr = 32'h101; dbus_size = 2'd1;
    #1;
    chk("mis_lh_odd", dbus_misaligned, 1);
    dbus_addr = 32'h102; dbus_size = 2'd1;
    #1;
    chk("lh_even_mis", dbus_misaligned, 0);
    chk("lh_even_wait", dbus_wait, 1);
    dbus_rd_en = 1'b0;
    nxt();
    chk("mis_never_valid", mem_valid, 0);

    // Slow slave: ready after 4 wait cycles with an error
    dbus_rd_en = 1'b1; dbus_addr = 32'h400; dbus_size = 2'd2;
    nxt();
    for (int i = 0; i < 4; i++) begin
      chk("slow_valid", mem_valid, 1);
      chk("slow_addr", mem_addr, 32'h400);
      chk("slow_wait", dbus_wait, 1);
      nxt();
    end
    chk("slow_valid5", mem_valid, 1);
    mem_ready = 1'b1; mem_err = 1'b1; mem_rd_data = 32'hCAFEF00D;
    nxt();
    chk("slow_fault", dbus_access_fault, 1);
    chk("slow_err", dbus_err, 1);
    chk("slow_mis", dbus_misaligned, 0);
    chk("slow_wait_done", dbus_wait, 0);
    mem_ready = 1'b0; mem_err = 1'b0; dbus_rd_en = 1'b0;
    nxt();
    chk("slow_err_clear", dbus_err, 0);

    // Request held through DONE starts a second transaction
    dbus_rd_en = 1'b1; dbus_addr = 32'h800; dbus_size = 2'd2;
    mem_ready = 1'b1; mem_rd_data = 32'h12345678;
    nxt();
    nxt();
    chk("b2b_done1", dbus_rd_data, 32'h12345678);
    mem_rd_data = 32'h9ABCDEF0;
    nxt();
    chk("b2b_idle_wait", dbus_wait, 1);
    chk("b2b_idle_valid", mem_valid, 0);
    nxt();
    chk("b2b_bus_valid", mem_valid, 1);
    nxt();
    chk("b2b_done2", dbus_rd_data, 32'h9ABCDEF0);
    dbus_rd_en = 1'b0; mem_ready = 1'b0;
    nxt();

`ifdef DBUS_TIMEOUT_EN
    // Unresponsive slave is aborted after 8 BUS cycles
    dbus_rd_en = 1'b1; dbus_addr = 32'h600; dbus_size = 2'd2;
    nxt();
    for (int i = 0; i < 8; i++) begin
      chk("tmo_valid", mem_valid, 1);
      nxt();
    end
    chk("tmo_valid_drop", mem_valid, 0);
    chk("tmo_fault", dbus_access_fault, 1);
    chk("tmo_rdata", dbus_rd_data, 0);
    chk("tmo_wait", dbus_wait, 0);
    dbus_rd_en = 1'b0;
    nxt();
`else
    // Without the timeout the bus waits on an idle slave
    dbus_rd_en = 1'b1; dbus_addr = 32'h600; dbus_size = 2'd2;
    nxt();
    for (int i = 0; i < 20; i++) begin
      chk("notmo_valid", mem_valid, 1);
      nxt();
    end
    mem_ready = 1'b1; mem_rd_data = 32'h55AA55AA;
    nxt();
    chk("notmo_rdata", dbus_rd_data, 32'h55AA55AA);
    chk("notmo_fault", dbus_access_fault, 0);
    mem_ready = 1'b0; dbus_rd_en = 1'b0;
    nxt();
`endif

    // Asynchronous reset in the middle of BUS
    dbus_rd_en = 1'b1; dbus_addr = 32'h700; dbus_size = 2'd2;
    nxt();
    chk("arst_pre_valid", mem_valid, 1);
    dbus_rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", mem_valid, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wait", dbus_wait, 0);
    chk("arst_rdata", dbus_rd_data, 0);
    nxt();
    rst_n = 1'b1;
    nxt();
    chk("arst_idle_valid", mem_valid, 0);
    chk("arst_idle_wait", dbus_wait, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
